rob_commit_buffer: RTL and testbench
====================================

Name: rob_commit_buffer

Overview:
- In-order reorder buffer between rename/dispatch and architectural commit.
- Allocates one entry per dispatched instruction in program order.
- Marks entries completed when matching FU writebacks (fu_output_t) arrive.
- Retires completed entries from the head on the commit port. The ARF-update unit consumes prd/ard/needprf2arf to copy PRF to ARF.

Parameters:
- NR_ENTRIES, C::NR_ROB_ENTRIES (32): entry count. Must be a power of two and >= 2.
- NR_WB, C::NR_WB_PORTS (1): number of writeback ports.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush_i  in  1  discard all entries (mispredict/trap)
- dispatch_valid_i  in  1  new entry offered
- dispatch_ready_o  out  1  entry accepted when valid&&ready
- dispatch_entry_i  in  rob_entry_t  new entry; completed field ignored
- dispatch_rob_id_o  out  rob_id_t  index that will be allocated (current tail)
- wb_valid_i  in  NR_WB  per-port writeback strobe
- wb_data_i  in  NR_WB x fu_output_t  writeback payload; only id is used
- commit_valid_o  out  1  head entry completed and retirable
- commit_ready_i  in  1  consumer accepts head
- commit_entry_o  out  rob_entry_t  head entry contents
- count_o  out  $clog2(NR_ENTRIES)+1  occupied entries
- empty_o  out  1  count_o==0
- full_o  out  1  count_o==NR_ENTRIES

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous, active-high (rst).
- Storage: circular array of rob_entry_t plus a per-entry valid bit.
  - head/tail pointers are $clog2(NR_ENTRIES)+1 bits; the MSB is the wrap bit.
  - empty: head==tail. full: index bits equal and wrap bits differ.
- Reset values: head=tail=0, all valid=0, all completed=0. Outputs: dispatch_ready_o=1, commit_valid_o=0, count_o=0, empty_o=1, full_o=0, dispatch_rob_id_o=0.
- Dispatch:
  - dispatch_ready_o = !full_o, from registered state only. There is no combinational path from commit_ready_i.
  - On valid&&ready: entry[tail] <= dispatch_entry_i with completed=0 and valid=1, then tail++ (wraps at NR_ENTRIES).
  - Dispatch while full is dropped (ready=0). Simultaneous commit does not free space in the same cycle.
- Writeback:
  - Each port with wb_valid_i compares wb_data_i.id against the id of every valid entry.
  - On a match, completed <= 1 at the next edge.
  - A writeback with no match is ignored; the simulation assertion fires.
  - Two ports matching the same entry is legal; the entry is set once.
  - A writeback in the same cycle as that entry's dispatch does not match.
- Commit:
  - commit_valid_o = valid[head] && entry[head].completed && !flush_i.
  - commit_entry_o = entry[head], held stable while valid&&!ready.
  - On valid&&ready: valid[head] <= 0, head++.
  - Latency: writeback edge -> commit_valid_o high the next cycle. Minimum dispatch-to-commit is 2 cycles.
- Simultaneous dispatch and commit: both happen and count_o is unchanged. This is legal when full_o=0, including when tail wraps to index 0 in the same cycle head advances.
- Flush:
  - Takes priority over dispatch, writeback and commit in the same cycle. None of those take effect.
  - Next cycle: head=tail=0, all valid/completed cleared, outputs at reset values.
  - Flush while commit_valid_o would otherwise be high: no retire occurs.
- Reset mid-operation: identical to flush plus a full register reinit. rst has priority over flush_i.
- count_o = tail - head (pointer-width subtraction; wrap bit included).
- Assertions:
  - No accepted dispatch while full.
  - No commit handshake while empty.
  - Completed is never set on an invalid entry.
  - Entry ids are unique among valid entries.

Decomposition:
- rob_entry_t, fu_output_t, rob_id_t, id_t and NR_ROB_ENTRIES stay in package C.
- Add to C: rob_ptr_t (rob_id_t plus wrap bit) and rob_count_t.
- One natural sub-module: rob_wb_match. It is a combinational CAM taking entry ids, valid bits and the NR_WB writeback ids, and producing an NR_ENTRIES-wide set_completed vector.

Test Plan:
- Reset then idle -> empty_o=1, dispatch_ready_o=1, commit_valid_o=0, count_o=0.
- Dispatch ids 10,11,12 back-to-back. Writeback ids 12 then 10 -> commit_valid_o rises 1 cycle after the wb of id 10 with commit_entry_o.id=10. Id 11 blocks id 12 until wb 11 arrives; commits occur in order 10,11,12.
- Dispatch 32 entries -> full_o=1, dispatch_ready_o=0, count_o=32. A 33rd offer is not accepted. Complete and commit one -> full_o=0 next cycle and dispatch_rob_id_o=0 (wrap).
- Steady state with count=5: dispatch, writeback and commit every cycle for 100 cycles with head/tail wrapping -> count_o stays 5 and commit order matches dispatch order.
- Hold commit_ready_i=0 for 4 cycles with the head completed -> commit_valid_o stays 1 and commit_entry_o is stable. Release -> a single retire.
- With 6 entries, 3 completed: assert flush_i together with dispatch_valid_i and commit_ready_i -> no retire, no allocate. Next cycle empty_o=1 and count_o=0. A later wb of an old id causes no state change.

Source files
------------

// File: rtl/rob_commit_buffer_pkg.sv
// Shared types for the reorder buffer: entry/writeback payloads, ROB index,
// pointer (index plus wrap bit) and occupancy count.
package C;

    localparam int NR_ROB_ENTRIES = 32;
    localparam int NR_WB_PORTS    = 1;
    localparam int ROB_ID_W       = $clog2(NR_ROB_ENTRIES);

    typedef logic [7:0]          id_t;
    typedef logic [ROB_ID_W-1:0] rob_id_t;
    typedef logic [ROB_ID_W:0]   rob_ptr_t;
    typedef logic [ROB_ID_W:0]   rob_count_t;

    typedef struct packed {
        id_t        id;
        logic [4:0] ard;
        logic [5:0] prd;
        logic       needprf2arf;
        logic       completed;
    } rob_entry_t;

    typedef struct packed {
        id_t         id;
        logic [31:0] data;
    } fu_output_t;

    function automatic logic id_match(input logic en, input id_t a, input id_t b);
        return en && (a == b);
    endfunction

endpackage

// File: rtl/rob_commit_buffer_checker.sv
// Simulation-time invariants of the reorder buffer.
module rob_commit_buffer_checker
    import C::*;
#(
    parameter int NR_ENTRIES = C::NR_ROB_ENTRIES,
    parameter int NR_WB      = C::NR_WB_PORTS
) (
    input logic                  clk,
    input logic                  rst,
    input logic                  flush_i,
    input logic                  dispatch_valid_i,
    input logic                  dispatch_ready_i,
    input logic                  full_i,
    input logic                  empty_i,
    input logic                  commit_valid_i,
    input logic                  commit_ready_i,
    input logic [NR_ENTRIES-1:0] valid_i,
    input logic [NR_ENTRIES-1:0] done_i,
    input id_t                   ids_i [NR_ENTRIES],
    input logic [NR_WB-1:0]      wb_valid_i,
    input logic [NR_WB-1:0]      wb_hit_i
);

    logic dup_s;

    // Any pair of live entries sharing an id.
    always_comb begin
        dup_s = 1'b0;
        for (int i = 0; i < NR_ENTRIES; i++) begin
            for (int j = i + 1; j < NR_ENTRIES; j++) begin
                dup_s = dup_s | (valid_i[i] && valid_i[j] && (ids_i[i] == ids_i[j]));
            end
        end
    end

    a_no_dispatch_full: assert property (@(posedge clk) disable iff (rst)
        !(dispatch_valid_i && dispatch_ready_i && full_i))
        else $error("dispatch accepted while full");

    a_no_commit_empty: assert property (@(posedge clk) disable iff (rst)
        !(commit_valid_i && commit_ready_i && empty_i))
        else $error("commit handshake while empty");

    a_done_implies_valid: assert property (@(posedge clk) disable iff (rst)
        (done_i & ~valid_i) == '0)
        else $error("completed flag on an invalid entry");

    a_unique_ids: assert property (@(posedge clk) disable iff (rst) !dup_s)
        else $error("duplicate id among valid entries");

    for (genvar p = 0; p < NR_WB; p++) begin : g_wb_hit
        a_wb_hits: assert property (@(posedge clk) disable iff (rst || flush_i)
            wb_valid_i[p] |-> wb_hit_i[p])
            else $warning("writeback on port %0d matched no entry", p);
    end

endmodule

// File: rtl/rob_wb_match.sv
// Writeback CAM: flags every valid entry whose id matches any strobed
// writeback port, and reports per port whether it hit anything.
module rob_wb_match
    import C::*;
#(
    parameter int NR_ENTRIES = C::NR_ROB_ENTRIES,
    parameter int NR_WB      = C::NR_WB_PORTS
) (
    input  id_t                   entry_ids_i [NR_ENTRIES],
    input  logic [NR_ENTRIES-1:0] entry_valid_i,
    input  logic [NR_WB-1:0]      wb_valid_i,
    input  id_t                   wb_ids_i [NR_WB],
    output logic [NR_ENTRIES-1:0] set_completed_o,
    output logic [NR_WB-1:0]      wb_hit_o
);

    logic hit_s;

    // Full entry x port compare; several ports hitting one entry just OR together.
    always_comb begin
        set_completed_o = '0;
        wb_hit_o        = '0;
        hit_s           = 1'b0;
        for (int e = 0; e < NR_ENTRIES; e++) begin
            for (int p = 0; p < NR_WB; p++) begin
                hit_s = id_match(entry_valid_i[e] && wb_valid_i[p], entry_ids_i[e], wb_ids_i[p]);
                set_completed_o[e] = set_completed_o[e] | hit_s;
                wb_hit_o[p]        = wb_hit_o[p] | hit_s;
            end
        end
    end

endmodule

// File: rtl/rob_commit_buffer.sv
// In-order reorder buffer: allocates at the tail on dispatch, marks entries
// complete on writeback, and retires completed entries from the head.
module rob_commit_buffer
    import C::*;
#(
    parameter int NR_ENTRIES = C::NR_ROB_ENTRIES,
    parameter int NR_WB      = C::NR_WB_PORTS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush_i,
    input  logic                          dispatch_valid_i,
    output logic                          dispatch_ready_o,
    input  rob_entry_t                    dispatch_entry_i,
    output logic [$clog2(NR_ENTRIES)-1:0] dispatch_rob_id_o,
    input  logic [NR_WB-1:0]              wb_valid_i,
    input  fu_output_t                    wb_data_i [NR_WB],
    output logic                          commit_valid_o,
    input  logic                          commit_ready_i,
    output rob_entry_t                    commit_entry_o,
    output logic [$clog2(NR_ENTRIES):0]   count_o,
    output logic                          empty_o,
    output logic                          full_o
);

    localparam int IDX_W = $clog2(NR_ENTRIES);
    localparam int PTR_W = IDX_W + 1;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [PTR_W-1:0] ptr_t;

    ptr_t                  head_q, head_d;
    ptr_t                  tail_q, tail_d;
    logic [NR_ENTRIES-1:0] valid_q, valid_d;
    logic [NR_ENTRIES-1:0] done_q, done_d;
    rob_entry_t            entry_q [NR_ENTRIES];
    rob_entry_t            entry_d [NR_ENTRIES];

    idx_t                  head_idx_s, tail_idx_s;
    logic                  full_s, empty_s;
    logic                  commit_valid_s, commit_fire_s, dispatch_fire_s;
    id_t                   entry_ids_s [NR_ENTRIES];
    id_t                   wb_ids_s [NR_WB];
    logic [NR_ENTRIES-1:0] set_completed_s;
    logic [NR_WB-1:0]      wb_hit_s;
    logic                  unused_wb_payload_s;

    assign head_idx_s = head_q[IDX_W-1:0];
    assign tail_idx_s = tail_q[IDX_W-1:0];
    assign empty_s    = (head_q == tail_q);
    assign full_s     = (head_idx_s == tail_idx_s) && (head_q[IDX_W] != tail_q[IDX_W]);

    assign commit_valid_s  = valid_q[head_idx_s] && done_q[head_idx_s] && !flush_i;
    assign commit_fire_s   = commit_valid_s && commit_ready_i;
    // Readiness depends only on registered occupancy, never on commit_ready_i.
    assign dispatch_fire_s = dispatch_valid_i && !full_s && !flush_i;

    assign dispatch_ready_o  = !full_s;
    assign dispatch_rob_id_o = tail_idx_s;
    assign commit_valid_o    = commit_valid_s;
    assign count_o           = tail_q - head_q;
    assign empty_o           = empty_s;
    assign full_o            = full_s;

    // Head entry with its live completion flag folded in.
    always_comb begin
        commit_entry_o           = entry_q[head_idx_s];
        commit_entry_o.completed = done_q[head_idx_s];
    end

    // CAM operands; only the writeback id participates in matching.
    always_comb begin
        unused_wb_payload_s = 1'b0;
        for (int e = 0; e < NR_ENTRIES; e++) begin
            entry_ids_s[e] = entry_q[e].id;
        end
        for (int p = 0; p < NR_WB; p++) begin
            wb_ids_s[p]         = wb_data_i[p].id;
            unused_wb_payload_s = unused_wb_payload_s ^ (^wb_data_i[p].data);
        end
    end

    rob_wb_match #(
        .NR_ENTRIES (NR_ENTRIES),
        .NR_WB      (NR_WB)
    ) u_wb_match (
        .entry_ids_i     (entry_ids_s),
        .entry_valid_i   (valid_q),
        .wb_valid_i      (wb_valid_i),
        .wb_ids_i        (wb_ids_s),
        .set_completed_o (set_completed_s),
        .wb_hit_o        (wb_hit_s)
    );

    // Next state: flush wins outright; otherwise writeback, then retire, then allocate.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        valid_d = valid_q;
        done_d  = done_q;
        entry_d = entry_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            valid_d = '0;
            done_d  = '0;
        end else begin
            done_d = done_q | set_completed_s;
            if (commit_fire_s) begin
                valid_d[head_idx_s] = 1'b0;
                done_d[head_idx_s]  = 1'b0;
                head_d              = head_q + ptr_t'(1'b1);
            end else begin
                head_d = head_q;
            end
            if (dispatch_fire_s) begin
                entry_d[tail_idx_s]           = dispatch_entry_i;
                entry_d[tail_idx_s].completed = 1'b0;
                valid_d[tail_idx_s]           = 1'b1;
                done_d[tail_idx_s]            = 1'b0;
                tail_d                        = tail_q + ptr_t'(1'b1);
            end else begin
                tail_d = tail_q;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= '0;
            done_q  <= '0;
            for (int e = 0; e < NR_ENTRIES; e++) begin
                entry_q[e] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            entry_q <= entry_d;
        end
    end

    rob_commit_buffer_checker #(
        .NR_ENTRIES (NR_ENTRIES),
        .NR_WB      (NR_WB)
    ) u_checker (
        .clk              (clk),
        .rst              (rst),
        .flush_i          (flush_i),
        .dispatch_valid_i (dispatch_valid_i),
        .dispatch_ready_i (dispatch_ready_o),
        .full_i           (full_s),
        .empty_i          (empty_s),
        .commit_valid_i   (commit_valid_s),
        .commit_ready_i   (commit_ready_i),
        .valid_i          (valid_q),
        .done_i           (done_q),
        .ids_i            (entry_ids_s),
        .wb_valid_i       (wb_valid_i),
        .wb_hit_i         (wb_hit_s)
    );

endmodule

// File: tb/tb_rob_commit_buffer.sv
// Self-checking bench for rob_commit_buffer against a queue-based ROB model.
module tb_rob_commit_buffer;
    import C::*;

    localparam int N = C::NR_ROB_ENTRIES;

    logic       clk = 1'b0;
    logic       rst, flush, dv, dready, cvalid, cready, empty, full;
    rob_entry_t dentry, centry;
    logic [4:0] rob_id;
    logic [5:0] count;
    logic [0:0] wbv;
    fu_output_t wbd [1];

    int checks = 0;
    int errors = 0;

    typedef struct {
        rob_entry_t e;
        bit         done;
    } m_t;

    m_t mq[$];
    int m_tail  = 0;
    int next_id = 0;

    always #5 clk = ~clk;

    rob_commit_buffer dut (
        .clk               (clk),
        .rst               (rst),
        .flush_i           (flush),
        .dispatch_valid_i  (dv),
        .dispatch_ready_o  (dready),
        .dispatch_entry_i  (dentry),
        .dispatch_rob_id_o (rob_id),
        .wb_valid_i        (wbv),
        .wb_data_i         (wbd),
        .commit_valid_o    (cvalid),
        .commit_ready_i    (cready),
        .commit_entry_o    (centry),
        .count_o           (count),
        .empty_o           (empty),
        .full_o            (full)
    );

    function automatic rob_entry_t mk_entry(input int id);
        rob_entry_t e;
        e.id          = id_t'(id);
        e.ard         = 5'($urandom);
        e.prd         = 6'($urandom);
        e.needprf2arf = 1'($urandom);
        e.completed   = 1'($urandom);
        return e;
    endfunction

    function automatic bit m_cvalid();
        return (mq.size() > 0) && mq[0].done && !flush;
    endfunction

    function automatic rob_entry_t m_head();
        rob_entry_t e;
        e           = mq[0].e;
        e.completed = 1'b1;
        return e;
    endfunction

    // Reference ROB: an ordered list of in-flight instructions.
    task automatic model_edge();
        int n0;
        bit do_commit;
        m_t m;
        n0 = mq.size();
        if (rst || flush) begin
            mq.delete();
            m_tail = 0;
        end else begin
            do_commit = m_cvalid() && cready;
            if (wbv[0]) begin
                foreach (mq[i]) if (mq[i].e.id == wbd[0].id) mq[i].done = 1'b1;
            end
            if (do_commit) void'(mq.pop_front());
            if (dv && n0 < N) begin
                m.e    = dentry;
                m.done = 1'b0;
                mq.push_back(m);
                m_tail  = (m_tail + 1) % N;
                next_id = next_id + 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        dv = 1'b0; flush = 1'b0; wbv = 1'b0; cready = 1'b0;
    endtask

    task automatic dispatch_new();
        dentry = mk_entry(next_id % 256);
        dv     = 1'b1;
    endtask

    task automatic do_flush();
        idle(); flush = 1'b1; tick(); flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle(); dentry = '0; wbd[0] = '0;
        tick(); tick();
        rst = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0b want 1", empty); end
        checks++; if (dready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", dready); end
        checks++; if (cvalid !== 1'b0) begin errors++; $display("FAIL reset_cvalid: got %0b want 0", cvalid); end
        checks++; if (count !== 6'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (rob_id !== 5'd0) begin errors++; $display("FAIL reset_rob_id: got %0d want 0", rob_id); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b want 0", full); end
        tick();
        checks++; if (count !== 6'd0 || empty !== 1'b1) begin errors++; $display("FAIL idle_state: count %0d empty %0b want 0/1", count, empty); end
    endtask

    task automatic test_in_order();
        idle(); cready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            dentry = mk_entry(10 + k); dv = 1'b1; tick();
        end
        dv = 1'b0;
        wbv = 1'b1; wbd[0].id = 8'd12; wbd[0].data = $urandom; tick();
        checks++; if (cvalid !== 1'b0) begin errors++; $display("FAIL order_blocked10: cvalid %0b want 0", cvalid); end
        wbd[0].id = 8'd10; tick(); wbv = 1'b0;
        checks++; if (cvalid !== 1'b1 || centry.id !== 8'd10) begin errors++; $display("FAIL order_commit10: cvalid %0b id %0d want 1/10", cvalid, centry.id); end
        checks++; if (count !== 6'd3) begin errors++; $display("FAIL order_count3: got %0d want 3", count); end
        tick();
        checks++; if (cvalid !== 1'b0 || centry.id !== 8'd11) begin errors++; $display("FAIL order_blocked11: cvalid %0b id %0d want 0/11", cvalid, centry.id); end
        wbv = 1'b1; wbd[0].id = 8'd11; tick(); wbv = 1'b0;
        checks++; if (cvalid !== 1'b1 || centry.id !== 8'd11) begin errors++; $display("FAIL order_commit11: cvalid %0b id %0d want 1/11", cvalid, centry.id); end
        tick();
        checks++; if (cvalid !== 1'b1 || centry.id !== 8'd12) begin errors++; $display("FAIL order_commit12: cvalid %0b id %0d want 1/12", cvalid, centry.id); end
        tick();
        checks++; if (empty !== 1'b1 || count !== 6'd0) begin errors++; $display("FAIL order_drained: empty %0b count %0d want 1/0", empty, count); end
        cready = 1'b0;
    endtask

    task automatic test_full();
        next_id = 20;
        do_flush();
        for (int k = 0; k < N; k++) begin dispatch_new(); tick(); end
        dv = 1'b0;
        checks++; if (full !== 1'b1 || dready !== 1'b0) begin errors++; $display("FAIL full_flags: full %0b ready %0b want 1/0", full, dready); end
        checks++; if (count !== 6'd32) begin errors++; $display("FAIL full_count: got %0d want 32", count); end
        checks++; if (rob_id !== 5'd0) begin errors++; $display("FAIL full_rob_id: got %0d want 0", rob_id); end
        dispatch_new(); tick(); dv = 1'b0;
        checks++; if (count !== 6'd32 || full !== 1'b1) begin errors++; $display("FAIL full_drop33: count %0d full %0b want 32/1", count, full); end
        wbv = 1'b1; wbd[0].id = mq[0].e.id; tick(); wbv = 1'b0;
        checks++; if (cvalid !== 1'b1) begin errors++; $display("FAIL full_head_ready: cvalid %0b want 1", cvalid); end
        cready = 1'b1; dispatch_new(); tick(); cready = 1'b0; dv = 1'b0;
        checks++; if (full !== 1'b0 || dready !== 1'b1) begin errors++; $display("FAIL full_freed: full %0b ready %0b want 0/1", full, dready); end
        checks++; if (count !== 6'd31) begin errors++; $display("FAIL full_no_same_cycle_reuse: count %0d want 31", count); end
        checks++; if (rob_id !== 5'd0) begin errors++; $display("FAIL full_wrap_id: got %0d want 0", rob_id); end
    endtask

    task automatic test_steady();
        int idx;
        do_flush();
        for (int k = 0; k < 5; k++) begin dispatch_new(); tick(); end
        dv = 1'b0;
        for (int k = 0; k < 5; k++) begin
            wbv = 1'b1; wbd[0].id = mq[k].e.id; tick();
        end
        wbv = 1'b0;
        for (int c = 0; c < 100; c++) begin
            cready = 1'b1; dispatch_new();
            idx = -1;
            foreach (mq[i]) if (idx < 0 && !mq[i].done) idx = i;
            wbv = (idx >= 0);
            if (idx >= 0) wbd[0].id = mq[idx].e.id;
            checks++; if (count !== 6'd5) begin errors++; $display("FAIL steady_count c%0d: got %0d want 5", c, count); end
            checks++; if (cvalid !== 1'b1 || centry !== m_head()) begin errors++; $display("FAIL steady_commit c%0d: cvalid %0b entry %h want 1/%h", c, cvalid, centry, m_head()); end
            checks++; if (rob_id !== 5'(m_tail)) begin errors++; $display("FAIL steady_rob_id c%0d: got %0d want %0d", c, rob_id, m_tail); end
            tick();
        end
        idle();
    endtask

    task automatic test_hold();
        rob_entry_t held;
        do_flush();
        for (int k = 0; k < 2; k++) begin dispatch_new(); tick(); end
        dv = 1'b0;
        wbv = 1'b1; wbd[0].id = mq[0].e.id; tick(); wbv = 1'b0;
        held = m_head();
        for (int c = 0; c < 4; c++) begin
            checks++; if (cvalid !== 1'b1 || centry !== held) begin errors++; $display("FAIL hold_stable c%0d: cvalid %0b entry %h want 1/%h", c, cvalid, centry, held); end
            tick();
        end
        cready = 1'b1; tick(); cready = 1'b0;
        checks++; if (count !== 6'd1 || cvalid !== 1'b0) begin errors++; $display("FAIL hold_release: count %0d cvalid %0b want 1/0", count, cvalid); end
        tick();
        checks++; if (count !== 6'd1) begin errors++; $display("FAIL hold_single_retire: count %0d want 1", count); end
    endtask

    task automatic test_flush();
        id_t old_id;
        do_flush();
        for (int k = 0; k < 6; k++) begin dispatch_new(); tick(); end
        dv = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wbv = 1'b1; wbd[0].id = mq[k].e.id; tick();
        end
        wbv = 1'b0;
        old_id = mq[0].e.id;
        checks++; if (cvalid !== 1'b1 || count !== 6'd6) begin errors++; $display("FAIL flush_pre: cvalid %0b count %0d want 1/6", cvalid, count); end
        flush = 1'b1; cready = 1'b1; dispatch_new(); #1;
        checks++; if (cvalid !== 1'b0) begin errors++; $display("FAIL flush_masks_commit: cvalid %0b want 0", cvalid); end
        tick(); flush = 1'b0; dv = 1'b0; cready = 1'b0;
        checks++; if (empty !== 1'b1 || count !== 6'd0) begin errors++; $display("FAIL flush_empty: empty %0b count %0d want 1/0", empty, count); end
        checks++; if (dready !== 1'b1 || full !== 1'b0 || rob_id !== 5'd0 || cvalid !== 1'b0) begin errors++; $display("FAIL flush_outputs: ready %0b full %0b id %0d cvalid %0b want 1/0/0/0", dready, full, rob_id, cvalid); end
        wbv = 1'b1; wbd[0].id = old_id; cready = 1'b1; tick(); wbv = 1'b0; cready = 1'b0;
        checks++; if (empty !== 1'b1 || count !== 6'd0 || cvalid !== 1'b0) begin errors++; $display("FAIL flush_stale_wb: empty %0b count %0d cvalid %0b want 1/0/0", empty, count, cvalid); end
        dispatch_new(); tick(); dv = 1'b0;
        checks++; if (count !== 6'd1 || rob_id !== 5'd1 || cvalid !== 1'b0) begin errors++; $display("FAIL flush_realloc: count %0d id %0d cvalid %0b want 1/1/0", count, rob_id, cvalid); end
    endtask

    task automatic test_random();
        int idx;
        do_flush();
        for (int c = 0; c < 400; c++) begin
            idle();
            if ($urandom_range(0, 3) != 0) dispatch_new();
            cready = ($urandom_range(0, 2) != 0);
            flush  = ($urandom_range(0, 49) == 0);
            if (mq.size() > 0 && $urandom_range(0, 1) == 1) begin
                idx = $urandom_range(0, mq.size() - 1);
                wbv = 1'b1; wbd[0].id = mq[idx].e.id; wbd[0].data = $urandom;
            end
            #1;
            checks++; if (count !== 6'(mq.size()) || empty !== (mq.size() == 0) || full !== (mq.size() == N)) begin
                errors++; $display("FAIL rand_occupancy c%0d: count %0d empty %0b full %0b want %0d", c, count, empty, full, mq.size());
            end
            checks++; if (dready !== (mq.size() != N) || rob_id !== 5'(m_tail)) begin
                errors++; $display("FAIL rand_dispatch c%0d: ready %0b id %0d want %0b/%0d", c, dready, rob_id, mq.size() != N, m_tail);
            end
            checks++; if (cvalid !== m_cvalid() || (m_cvalid() && centry !== m_head())) begin
                errors++; $display("FAIL rand_commit c%0d: cvalid %0b entry %h want %0b", c, cvalid, centry, m_cvalid());
            end
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_full();
        test_steady();
        test_hold();
        test_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
